// File: rtl/rxclk_capture_monitor.sv
// ---------------------------------------------------------------------------
// rxclk_capture_monitor
//
// SYSCLK-domain lock tracker for NUM_CH RXCLK->SYSCLK transfer channels.
// Each channel watches its already-registered capture-error bit. It declares
// lock after LOCK_CYCLES consecutive clean cycles. It drops lock and issues
// a one-cycle realign request when ERR_THRESH errors land inside one
// WINDOW-cycle window. It also keeps a saturating total-error count and a
// sticky "error while locked" flag.
//
// Ports:
//   sysclk_i       system clock (only clock)
//   rst_i          asynchronous, active-high reset
//   enable_i       per-channel monitor enable (level)
//   capture_err_i  per-channel capture-error bit, one per SYSCLK cycle
//   clear_i        single-cycle pulse; zeroes err_count_o and sticky_err_o
//   locked_o       channel is in LOCKED
//   all_locked_o   every enabled channel locked, at least one enabled
//   realign_o      one-cycle request to re-phase a channel's RXCLK capture
//   sticky_err_o   set on any error while LOCKED
//   err_count_o    saturating error counts, channel k at [k*CNT_WIDTH +: CNT_WIDTH]
// ---------------------------------------------------------------------------
module rxclk_capture_monitor #(
  parameter int NUM_CH        = 4,
  parameter int LOCK_CYCLES   = 1024,
  parameter int WINDOW        = 65536,
  parameter int ERR_THRESH    = 4,
  parameter int SETTLE_CYCLES = 16,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                        sysclk_i,
  input  logic                        rst_i,
  input  logic [NUM_CH-1:0]           enable_i,
  input  logic [NUM_CH-1:0]           capture_err_i,
  input  logic                        clear_i,
  output logic [NUM_CH-1:0]           locked_o,
  output logic                        all_locked_o,
  output logic [NUM_CH-1:0]           realign_o,
  output logic [NUM_CH-1:0]           sticky_err_o,
  output logic [NUM_CH*CNT_WIDTH-1:0] err_count_o
);

  // Counter widths: clean, window and settle counters only ever hold
  // 0..N-1 because the terminal value triggers the state change instead.
  localparam int CLEAN_W = $clog2(LOCK_CYCLES);
  localparam int WIN_W   = $clog2(WINDOW);
  localparam int SET_W   = $clog2(SETTLE_CYCLES + 1);
  localparam int WERR_W  = $clog2(ERR_THRESH + 1);

  localparam logic [CLEAN_W-1:0] CLEAN_LAST  = CLEAN_W'(LOCK_CYCLES - 1);
  localparam logic [WIN_W-1:0]   WIN_LAST    = WIN_W'(WINDOW - 1);
  localparam logic [SET_W-1:0]   SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [WERR_W-1:0]  WERR_LIMIT  = WERR_W'(ERR_THRESH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    REALIGN = 2'd3
  } state_t;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    state_t               state_q, state_d;
    logic [CLEAN_W-1:0]   clean_q, clean_d;
    logic [WIN_W-1:0]     win_q, win_d;
    logic [WERR_W-1:0]    werr_q, werr_d;
    logic [SET_W-1:0]     settle_q, settle_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 sticky_q, sticky_d;
    logic                 locked_q, locked_d;
    logic                 realign_q, realign_d;
    logic                 err;
    logic                 wrap;
    logic [WERR_W-1:0]    werr_next;

    assign err = capture_err_i[k];

    always_ff @(posedge sysclk_i or posedge rst_i) begin
      if (rst_i) begin
        state_q   <= IDLE;
        clean_q   <= '0;
        win_q     <= '0;
        werr_q    <= '0;
        settle_q  <= '0;
        cnt_q     <= '0;
        sticky_q  <= 1'b0;
        locked_q  <= 1'b0;
        realign_q <= 1'b0;
      end else begin
        state_q   <= state_d;
        clean_q   <= clean_d;
        win_q     <= win_d;
        werr_q    <= werr_d;
        settle_q  <= settle_d;
        cnt_q     <= cnt_d;
        sticky_q  <= sticky_d;
        locked_q  <= locked_d;
        realign_q <= realign_d;
      end
    end

    // Lock FSM
    always_comb begin
      state_d   = state_q;
      clean_d   = clean_q;
      win_d     = win_q;
      werr_d    = werr_q;
      settle_d  = settle_q;
      realign_d = 1'b0;
      wrap      = (win_q == WIN_LAST);
      // The wrap cycle opens the new window, so its error starts from zero.
      werr_next = (wrap ? '0 : werr_q) + WERR_W'(err);

      if (!enable_i[k]) begin
        state_d  = IDLE;
        clean_d  = '0;
        win_d    = '0;
        werr_d   = '0;
        settle_d = '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            state_d = ACQUIRE;
            clean_d = '0;
          end
          ACQUIRE: begin
            if (err) begin
              clean_d = '0;
            end else if (clean_q == CLEAN_LAST) begin
              state_d = LOCKED;
              clean_d = '0;
              win_d   = '0;
              werr_d  = '0;
            end else begin
              clean_d = clean_q + CLEAN_W'(1);
            end
          end
          LOCKED: begin
            win_d = wrap ? '0 : win_q + WIN_W'(1);
            if (werr_next >= WERR_LIMIT) begin
              state_d   = REALIGN;
              realign_d = 1'b1;
              settle_d  = '0;
              win_d     = '0;
              werr_d    = '0;
            end else begin
              werr_d = werr_next;
            end
          end
          REALIGN: begin
            // Errors are deliberately ignored while the capture phase moves.
            if (settle_q == SETTLE_LAST) begin
              state_d  = ACQUIRE;
              clean_d  = '0;
              settle_d = '0;
            end else begin
              settle_d = settle_q + SET_W'(1);
            end
          end
          default: state_d = IDLE;
        endcase
      end
      locked_d = (state_d == LOCKED);
    end

    // Error bookkeeping; clear wins over a same-cycle error.
    always_comb begin
      cnt_d    = cnt_q;
      sticky_d = sticky_q;
      if (clear_i) begin
        cnt_d    = '0;
        sticky_d = 1'b0;
      end else if (err && (state_q != IDLE)) begin
        cnt_d = sat_inc(cnt_q);
        if (state_q == LOCKED) sticky_d = 1'b1;
      end
    end

    assign locked_o[k]                          = locked_q;
    assign realign_o[k]                         = realign_q;
    assign sticky_err_o[k]                      = sticky_q;
    assign err_count_o[k*CNT_WIDTH +: CNT_WIDTH] = cnt_q;
  end

  // Aggregate lock built from registered per-channel lock, hence one extra cycle.
  logic all_locked_q, all_locked_d;

  always_comb begin
    all_locked_d = (&(locked_o | ~enable_i)) & (|enable_i);
  end

  always_ff @(posedge sysclk_i or posedge rst_i) begin
    if (rst_i) all_locked_q <= 1'b0;
    else       all_locked_q <= all_locked_d;
  end

  assign all_locked_o = all_locked_q;

endmodule

// File: tb/tb_rxclk_capture_monitor.sv
module tb_rxclk_capture_monitor;

  logic       sysclk_i = 1'b0;
  logic       rst_i;
  logic [1:0] enable_i;
  logic [1:0] capture_err_i;
  logic       clear_i;
  logic [1:0] locked_o;
  logic       all_locked_o;
  logic [1:0] realign_o;
  logic [1:0] sticky_err_o;
  logic [7:0] err_count_o;

  int errors = 0;
  int checks = 0;

  rxclk_capture_monitor #(
    .NUM_CH(2), .LOCK_CYCLES(8), .WINDOW(32), .ERR_THRESH(2),
    .SETTLE_CYCLES(4), .CNT_WIDTH(4)
  ) dut (
    .sysclk_i(sysclk_i), .rst_i(rst_i), .enable_i(enable_i),
    .capture_err_i(capture_err_i), .clear_i(clear_i), .locked_o(locked_o),
    .all_locked_o(all_locked_o), .realign_o(realign_o),
    .sticky_err_o(sticky_err_o), .err_count_o(err_count_o)
  );

  always #5 sysclk_i = ~sysclk_i;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sysclk_i);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_i = 1'b1; enable_i = 2'b00; capture_err_i = 2'b00; clear_i = 1'b0;
    tick(2);
    rst_i = 1'b0;
    chk("rst_locked", locked_o, 2'b00);
    chk("rst_all_locked", all_locked_o, 1'b0);
    chk("rst_realign", realign_o, 2'b00);
    chk("rst_sticky", sticky_err_o, 2'b00);
    chk("rst_count", err_count_o, 8'h00);

    // Lock acquisition on ch0 (edge 1 = IDLE->ACQUIRE, edges 2..9 clean)
    enable_i = 2'b01;
    tick(8);
    chk("acq_not_yet", locked_o[0], 1'b0);
    tick(1);                                   // E9
    chk("acq_locked", locked_o[0], 1'b1);
    chk("acq_all_lag", all_locked_o, 1'b0);
    tick(1);                                   // E10
    chk("acq_all_locked", all_locked_o, 1'b1);

    // Window wrap: errors at window cycles 30 (E40) and 33 (E43)
    tick(29);                                  // E39
    capture_err_i = 2'b01; tick(1);            // E40
    capture_err_i = 2'b00;
    chk("wrap_locked_a", locked_o[0], 1'b1);
    tick(2);                                   // E42
    capture_err_i = 2'b01; tick(1);            // E43
    capture_err_i = 2'b00;
    chk("wrap_no_realign", realign_o[0], 1'b0);
    chk("wrap_locked_b", locked_o[0], 1'b1);
    chk("wrap_count", err_count_o[3:0], 4'd2);
    chk("wrap_sticky", sticky_err_o[0], 1'b1);

    clear_i = 1'b1; tick(1);                   // E44
    clear_i = 1'b0;
    chk("clear_count", err_count_o[3:0], 4'd0);
    chk("clear_sticky", sticky_err_o[0], 1'b0);

    // Windowed loss: window cycle 5 (E79) and 20 (E94) of the third window
    tick(34);                                  // E78
    capture_err_i = 2'b01; tick(1);            // E79
    capture_err_i = 2'b00;
    chk("loss_first_locked", locked_o[0], 1'b1);
    chk("loss_first_count", err_count_o[3:0], 4'd1);
    tick(14);                                  // E93
    capture_err_i = 2'b01; tick(1);            // E94
    capture_err_i = 2'b00;
    chk("loss_realign", realign_o[0], 1'b1);
    chk("loss_unlocked", locked_o[0], 1'b0);
    chk("loss_sticky", sticky_err_o[0], 1'b1);
    chk("loss_count", err_count_o[3:0], 4'd2);
    tick(1);                                   // E95
    chk("loss_realign_pulse", realign_o[0], 1'b0);
    capture_err_i = 2'b01; tick(1);            // E96, error during REALIGN
    capture_err_i = 2'b00;
    chk("realign_err_count", err_count_o[3:0], 4'd3);
    chk("realign_no_repulse", realign_o[0], 1'b0);
    tick(9);                                   // E105
    chk("relock_not_yet", locked_o[0], 1'b0);
    tick(1);                                   // E106
    chk("relock", locked_o[0], 1'b1);

    // Disable while LOCKED: lock drops, counts kept
    enable_i = 2'b00; tick(1);                 // E107
    chk("dis_locked", locked_o[0], 1'b0);
    chk("dis_count", err_count_o[3:0], 4'd3);
    chk("dis_sticky", sticky_err_o[0], 1'b1);
    chk("dis_all_locked", all_locked_o, 1'b0);
    clear_i = 1'b1; tick(1);                   // E108
    clear_i = 1'b0;

    // Acquire restart: error when clean count is 7
    enable_i = 2'b01; tick(1);                 // E109 -> ACQUIRE
    tick(7);                                   // E116, clean=7
    capture_err_i = 2'b01; tick(1);            // E117
    capture_err_i = 2'b00;
    chk("restart_locked", locked_o[0], 1'b0);
    chk("restart_count", err_count_o[3:0], 4'd1);
    chk("restart_sticky", sticky_err_o[0], 1'b0);
    tick(7);                                   // E124
    chk("restart_not_yet", locked_o[0], 1'b0);
    tick(1);                                   // E125
    chk("restart_locked_late", locked_o[0], 1'b1);

    // Saturation: 20 errors on both channels; ch1 is IDLE and ignores them
    capture_err_i = 2'b11; tick(20);           // E145
    chk("sat_count0", err_count_o[3:0], 4'd15);
    chk("sat_count1_idle", err_count_o[7:4], 4'd0);
    chk("sat_sticky", sticky_err_o, 2'b01);
    capture_err_i = 2'b01; clear_i = 1'b1; tick(1);  // E146
    capture_err_i = 2'b00; clear_i = 1'b0;
    chk("sat_clear_count", err_count_o[3:0], 4'd0);
    chk("sat_clear_sticky", sticky_err_o[0], 1'b0);

    // Relock, then drive into REALIGN for the reset test
    tick(7);                                   // E153
    chk("pre_rst_not_yet", locked_o[0], 1'b0);
    tick(1);                                   // E154
    chk("pre_rst_locked", locked_o[0], 1'b1);
    capture_err_i = 2'b01; tick(2);            // E156
    capture_err_i = 2'b00;
    chk("pre_rst_realign", realign_o[0], 1'b1);
    chk("pre_rst_count", err_count_o[3:0], 4'd2);

    // Asynchronous reset in REALIGN
    #2 rst_i = 1'b1;
    #1;
    chk("async_locked", locked_o, 2'b00);
    chk("async_realign", realign_o, 2'b00);
    chk("async_sticky", sticky_err_o, 2'b00);
    chk("async_count", err_count_o, 8'h00);
    chk("async_all_locked", all_locked_o, 1'b0);
    #2 rst_i = 1'b0;
    // Back in IDLE: full 9-edge acquisition again
    tick(8);
    chk("post_rst_not_yet", locked_o[0], 1'b0);
    tick(1);
    chk("post_rst_locked", locked_o[0], 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
